// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared width and index helpers for the lane deserializer
package des_pkg;

  localparam int DES_RATIO_DEFAULT = 4;

  function automatic int des_phase_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Settle counter must hold the value RATIO itself, hence the +1.
  function automatic int des_settle_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int des_lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  function automatic int des_word_idx(input int k, input int lane, input int n_lanes);
    return k * n_lanes + lane;
  endfunction

  localparam int DES_PW = des_phase_w(DES_RATIO_DEFAULT);

  typedef logic [DES_PW-1:0] des_phase_t;

endpackage

// File: rtl/des_lane.sv
// rtl/des_lane.sv - one lane: RATIO-1 phase-addressed slots plus frame output register
module des_lane
  import des_pkg::*;
#(
  parameter int W     = 9,
  parameter int RATIO = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [des_phase_w(RATIO)-1:0] phase,
  input  logic                          cap,
  input  logic [W-1:0]                  din,
  output logic [RATIO*W-1:0]            dout
);

  localparam int PW = des_phase_w(RATIO);

  logic [W-1:0] slot [RATIO-1];

  // The last phase of a frame has no slot: that sample goes straight to dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RATIO - 1; s++) slot[s] <= '0;
      dout <= '0;
    end else if (en) begin
      for (int s = 0; s < RATIO - 1; s++) begin
        if (phase == PW'(s)) slot[s] <= din;
      end
      if (cap) begin
        for (int s = 0; s < RATIO - 1; s++) dout[s*W +: W] <= slot[s];
        dout[(RATIO-1)*W +: W] <= din;
      end
    end
  end

endmodule

// File: rtl/des_lanes_align.sv
// rtl/des_lanes_align.sv - N-lane 1:RATIO deserializer with frame-valid strobe and slip control
module des_lanes_align
  import des_pkg::*;
#(
  parameter  int W       = 9,
  parameter  int N_LANES = 8,
  parameter  int RATIO   = 4,
  localparam int PW      = des_phase_w(RATIO)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PW-1:0]                phase_init,
  input  logic                         en,
  input  logic [N_LANES*W-1:0]         in_data,
  input  logic                         slip_req,
  output logic                         slip_ready,
  output logic [N_LANES*RATIO*W-1:0]   out_data,
  output logic                         out_valid,
  output logic [PW-1:0]                phase,
  output logic                         clkout_div
);

  localparam int            SW   = des_settle_w(RATIO);
  localparam logic [PW-1:0] LAST = PW'(RATIO - 1);
  localparam logic [PW-1:0] HALF = PW'(RATIO / 2);

  logic [PW-1:0] phase_next;
  logic          accept;
  logic          cap;
  logic          skip;
  logic [SW-1:0] settle;

  // skip marks the extra edge after a slip taken on the capture edge: phase
  // stays at LAST but that edge must not capture a second frame.
  always_comb begin
    accept     = en && slip_req && slip_ready;
    cap        = en && (phase == LAST) && !skip;
    phase_next = phase;
    if (en && !accept) phase_next = (phase == LAST) ? '0 : phase + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= phase_init;
      clkout_div <= (phase_init < HALF);
      out_valid  <= 1'b0;
      slip_ready <= 1'b1;
      settle     <= '0;
      skip       <= 1'b0;
    end else begin
      phase      <= phase_next;
      clkout_div <= (phase_next < HALF);
      out_valid  <= cap;
      if (en) begin
        skip <= accept && (phase == LAST);
        if (accept) begin
          settle     <= SW'(RATIO);
          slip_ready <= 1'b0;
        end else if (settle != '0) begin
          settle <= settle - SW'(1);
          if (settle == SW'(1)) slip_ready <= 1'b1;
        end
      end
    end
  end

  logic [RATIO*W-1:0] lane_word [N_LANES];

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    des_lane #(
      .W     (W),
      .RATIO (RATIO)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .phase (phase),
      .cap   (cap),
      .din   (in_data[des_lane_lsb(l, W) +: W]),
      .dout  (lane_word[l])
    );
    for (genvar k = 0; k < RATIO; k++) begin : g_word
      assign out_data[des_word_idx(k, l, N_LANES)*W +: W] = lane_word[l][k*W +: W];
    end
  end

endmodule

// File: tb/tb_des_lanes_align.sv
// tb/tb_des_lanes_align.sv - directed bench for des_lanes_align (default and 2x8x12 builds)
module tb_des_lanes_align;
  import des_pkg::*;

  localparam int WA = 9;
  localparam int NA = 8;
  localparam int RA = 4;
  localparam int WB = 12;
  localparam int NB = 2;
  localparam int RB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_a, rst_b, en;
  logic [1:0]           phase_init_a;
  logic [2:0]           phase_init_b;
  logic [NA*WA-1:0]     in_data_a;
  logic [NB*WB-1:0]     in_data_b;
  logic                 slip_req_a, slip_req_b;
  logic                 slip_ready_a, slip_ready_b;
  logic [NA*RA*WA-1:0]  out_data_a;
  logic [NB*RB*WB-1:0]  out_data_b;
  logic                 out_valid_a, out_valid_b;
  des_phase_t           phase_a;
  logic [2:0]           phase_b;
  logic                 clkout_div_a, clkout_div_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int t      = 0;

  des_lanes_align u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .phase_init (phase_init_a),
    .en         (en),
    .in_data    (in_data_a),
    .slip_req   (slip_req_a),
    .slip_ready (slip_ready_a),
    .out_data   (out_data_a),
    .out_valid  (out_valid_a),
    .phase      (phase_a),
    .clkout_div (clkout_div_a)
  );

  des_lanes_align #(
    .W       (WB),
    .N_LANES (NB),
    .RATIO   (RB)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .phase_init (phase_init_b),
    .en         (en),
    .in_data    (in_data_b),
    .slip_req   (slip_req_b),
    .slip_ready (slip_ready_b),
    .out_data   (out_data_b),
    .out_valid  (out_valid_b),
    .phase      (phase_b),
    .clkout_div (clkout_div_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Lane l carries 16*l + t at sample index t.
  task automatic tick();
    for (int l = 0; l < NA; l++) in_data_a[l*WA +: WA] = WA'(16 * l + t);
    for (int l = 0; l < NB; l++) in_data_b[l*WB +: WB] = WB'(16 * l + t);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic step3(input string tag, input logic v, input logic r, input int p);
    tick();
    chk({tag, ".valid"}, out_valid_a, v);
    chk({tag, ".ready"}, slip_ready_a, r);
    chk({tag, ".phase"}, phase_a, p);
  endtask

  // Sample indices per phase slot; a negative index means a zero slot.
  function automatic logic [NA*RA*WA-1:0] frame_a(input int s0, input int s1, input int s2, input int s3);
    logic [NA*RA*WA-1:0] v;
    int s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    v = '0;
    for (int k = 0; k < RA; k++)
      for (int l = 0; l < NA; l++)
        v[(k*NA+l)*WA +: WA] = (s[k] < 0) ? '0 : WA'(16 * l + s[k]);
    return v;
  endfunction

  function automatic logic [NB*RB*WB-1:0] frame_b(input int base);
    logic [NB*RB*WB-1:0] v;
    for (int k = 0; k < RB; k++)
      for (int l = 0; l < NB; l++)
        v[(k*NB+l)*WB +: WB] = WB'(16 * l + base + k);
    return v;
  endfunction

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; en = 1'b1;
    phase_init_a = 2'd0; phase_init_b = 3'd0;
    slip_req_a = 1'b0; slip_req_b = 1'b0;
    in_data_a = '0; in_data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", out_valid_a, 1'b0);
    chk("rst.ready", slip_ready_a, 1'b1);
    chk("rst.phase", phase_a, 0);
    chk("rst.clkdiv", clkout_div_a, 1'b1);
    chk_wide("rst.data", out_data_a, '0);

    // Counting stimulus from phase 0
    rst_a = 1'b0;
    t = 0;
    step3("t0", 0, 1, 1);
    step3("t1", 0, 1, 2);
    step3("t2", 0, 1, 3);
    chk("t2.clkdiv", clkout_div_a, 1'b0);
    step3("t3", 1, 1, 0);
    chk("t3.clkdiv", clkout_div_a, 1'b1);
    chk_wide("t3.data", out_data_a, frame_a(0, 1, 2, 3));
    step3("t4", 0, 1, 1);
    step3("t5", 0, 1, 2);
    step3("t6", 0, 1, 3);
    step3("t7", 1, 1, 0);
    chk_wide("t7.data", out_data_a, frame_a(4, 5, 6, 7));

    // Single slip at phase 1
    step3("t8", 0, 1, 1);
    slip_req_a = 1'b1;
    step3("slip.t9", 0, 0, 1);
    slip_req_a = 1'b0;
    step3("slip.t10", 0, 0, 2);
    step3("slip.t11", 0, 0, 3);
    step3("slip.t12", 1, 0, 0);
    chk_wide("slip.t12.data", out_data_a, frame_a(8, 10, 11, 12));
    step3("slip.t13", 0, 1, 1);
    step3("slip.t14", 0, 1, 2);
    step3("slip.t15", 0, 1, 3);
    step3("slip.t16", 1, 1, 0);
    chk_wide("slip.t16.data", out_data_a, frame_a(13, 14, 15, 16));

    // slip_req held high: one accept every fifth edge
    slip_req_a = 1'b1;
    step3("hold.t17", 0, 0, 0);
    step3("hold.t18", 0, 0, 1);
    step3("hold.t19", 0, 0, 2);
    step3("hold.t20", 0, 0, 3);
    step3("hold.t21", 1, 1, 0);
    chk_wide("hold.t21.data", out_data_a, frame_a(18, 19, 20, 21));
    step3("hold.t22", 0, 0, 0);
    step3("hold.t23", 0, 0, 1);
    step3("hold.t24", 0, 0, 2);
    step3("hold.t25", 0, 0, 3);
    step3("hold.t26", 1, 1, 0);
    chk_wide("hold.t26.data", out_data_a, frame_a(23, 24, 25, 26));
    slip_req_a = 1'b0;

    // Slip on the capture edge
    step3("cap.t27", 0, 1, 1);
    step3("cap.t28", 0, 1, 2);
    step3("cap.t29", 0, 1, 3);
    slip_req_a = 1'b1;
    step3("cap.t30", 1, 0, 3);
    chk_wide("cap.t30.data", out_data_a, frame_a(27, 28, 29, 30));
    chk("cap.t30.clkdiv", clkout_div_a, 1'b0);
    slip_req_a = 1'b0;
    step3("cap.t31", 0, 0, 0);
    chk("cap.t31.clkdiv", clkout_div_a, 1'b1);
    step3("cap.t32", 0, 0, 1);
    step3("cap.t33", 0, 0, 2);
    step3("cap.t34", 0, 1, 3);
    step3("cap.t35", 1, 1, 0);
    chk_wide("cap.t35.data", out_data_a, frame_a(32, 33, 34, 35));

    // Three-cycle stall mid-frame; slip_req during stall is ignored
    step3("stall.t36", 0, 1, 1);
    en = 1'b0;
    step3("stall.t37", 0, 1, 1);
    slip_req_a = 1'b1;
    step3("stall.t38", 0, 1, 1);
    slip_req_a = 1'b0;
    step3("stall.t39", 0, 1, 1);
    en = 1'b1;
    step3("stall.t40", 0, 1, 2);
    step3("stall.t41", 0, 1, 3);
    step3("stall.t42", 1, 1, 0);
    chk_wide("stall.t42.data", out_data_a, frame_a(36, 40, 41, 42));

    // Async reset while a slip is settling and out_valid is high
    step3("ar.t43", 0, 1, 1);
    slip_req_a = 1'b1;
    step3("ar.t44", 0, 0, 1);
    slip_req_a = 1'b0;
    step3("ar.t45", 0, 0, 2);
    step3("ar.t46", 0, 0, 3);
    step3("ar.t47", 1, 0, 0);
    chk_wide("ar.t47.data", out_data_a, frame_a(43, 45, 46, 47));
    phase_init_a = 2'd2;
    rst_a = 1'b1;
    #1;
    chk("ar.valid", out_valid_a, 1'b0);
    chk("ar.ready", slip_ready_a, 1'b1);
    chk("ar.phase", phase_a, 2);
    chk("ar.clkdiv", clkout_div_a, 1'b0);
    chk_wide("ar.data", out_data_a, '0);
    step3("ar.t48", 0, 1, 2);
    rst_a = 1'b0;
    phase_init_a = 2'd0;
    step3("pi.t49", 0, 1, 3);
    step3("pi.t50", 1, 1, 0);
    chk_wide("pi.t50.data", out_data_a, frame_a(-1, -1, 49, 50));
    step3("pi.t51", 0, 1, 1);
    step3("pi.t52", 0, 1, 2);
    step3("pi.t53", 0, 1, 3);
    step3("pi.t54", 1, 1, 0);
    chk_wide("pi.t54.data", out_data_a, frame_a(51, 52, 53, 54));

    // 2-lane x 12-bit 1:8 build
    rst_b = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < RB; i++) begin
        tick();
        chk($sformatf("b.f%0d.i%0d.valid", f, i), out_valid_b, (i == RB - 1));
        chk($sformatf("b.f%0d.i%0d.phase", f, i), phase_b, (i + 1) % RB);
        chk($sformatf("b.f%0d.i%0d.clkdiv", f, i), clkout_div_b, (((i + 1) % RB) < RB / 2));
      end
      chk_wide($sformatf("b.f%0d.data", f), out_data_b, frame_b(55 + f * RB));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/des_lanes_align.md
Name: des_lanes_align

Overview:
Parametrised N-lane, 1:RATIO deserializer with frame-boundary slip control. It is the general successor to the fixed 8-lane x 9-bit 1:4 deserializer in the ADC-to-DSP datapath. It sits between the fast-clock ADC sample lanes and the slow DSP/FIFO domain. Instead of registered divided clocks, it produces a frame-valid strobe plus a divided clock. It adds enable, runtime phase preset and a slip handshake for word alignment.

Parameters:
W, 9, bits per sample per lane
N_LANES, 8, number of parallel input lanes
RATIO, 4, deserialization ratio; power of 2, >=2
PW, $clog2(RATIO), phase counter width (derived, localparam)

Ports:
clk  in  1  fast sample clock
rst  in  1  asynchronous, active-high reset
phase_init  in  PW  phase loaded on reset
en  in  1  sample enable; low freezes all state
in_data  in  N_LANES*W  lane l at [l*W +: W]
slip_req  in  1  request a one-sample frame-boundary shift
slip_ready  out  1  slip can be accepted
out_data  out  N_LANES*RATIO*W  word k*N_LANES+l = lane l sample at phase k
out_valid  out  1  one-cycle strobe, out_data updated
phase  out  PW  current phase counter
clkout_div  out  1  divided clock, registered; high while phase < RATIO/2 (previous cycle)

Behaviour:
- Reset (async assert): phase<=phase_init; out_data<=0; shift regs<=0; out_valid<=0; slip_ready<=1; settle counter<=0; clkout_div<=(phase_init < RATIO/2).
- en=0: phase, shift regs, out_data and settle counter hold. out_valid<=0. slip_req is ignored.
- en=1, each posedge: lane shift reg (RATIO-1 entries) captures in_data into slot phase.
- Frame capture: at a posedge with phase==RATIO-1, out_data<={in_data current, slots RATIO-2..0} per lane ordering above, and out_valid<=1. At all other edges out_valid<=0.
- Latency: the last sample of a frame appears on out_data 1 cycle after it is sampled. The first sample of a frame appears RATIO cycles after it is sampled.
- Phase counter: increments mod RATIO (wraps RATIO-1 -> 0), except on slip.
- Slip handshake: accepted on a posedge with en=1, slip_req=1 and slip_ready=1.
  - On accept, phase holds for that edge; the frame is lengthened by one sample. The sample is still written to slot phase, overwriting.
  - slip_ready<=0, and a settle counter loads RATIO.
  - The settle counter decrements on each en=1 edge. slip_ready returns to 1 on the edge where it reaches 0.
  - slip_req while slip_ready=0 is dropped, not queued.
- Slip on the capture edge (phase==RATIO-1): out_data still updates and out_valid still pulses. The next frame then begins with phase still RATIO-1, so its first out_valid occurs RATIO+1 cycles later.
- Slip on other edges: the next out_valid occurs RATIO+1 cycles after the previous one, with no missing strobe.
- clkout_div<=(phase_next < RATIO/2), registered, 50% duty except during a slip (one phase stretched).
- Reset mid-frame: partial frame is discarded. No out_valid until phase next reaches RATIO-1 from phase_init.
- phase_init sampled only while rst=1; changes outside reset have no effect.

Decomposition:
- Shared package des_pkg: the phase/settle width function and lane/word index helpers (word index k*N_LANES+l). No typedefs beyond a des_phase_t sized by PW.
- One sub-module is natural: des_lane, a per-lane W-bit x RATIO capture shift reg with capture enable. Instantiate N_LANES times via generate.
- Phase, slip and clkdiv control stays in the top.

Test Plan:
- Defaults, phase_init=0, en=1, lane l fed value 16*l+t at cycle t (t from 0): first out_valid on the cycle after t=3. out word k*8+l = 16*l+k. out_valid asserts every 4 cycles thereafter.
- phase_init=2 reset release: first out_valid 2 cycles after release. It carries 2 samples from the partial frame plus 2 zero slots from reset; subsequent frames are aligned.
- slip_req pulse at phase=1: one out_valid gap of 5 cycles, then period 4. Frame content is shifted by one sample. slip_ready low for exactly 4 en cycles.
- slip_req held high continuously: slips accepted every 5th edge only. slip_ready pattern 1,0,0,0,0,1. No queued extra slips.
- en toggled low for 3 cycles mid-frame: no out_valid during the stall. Frame content excludes stalled-cycle inputs. out_valid spacing = 4 + 3.
- rst asserted mid-frame while slip_ready=0: all outputs return to reset values immediately (async), including slip_ready=1 and out_data=0.
- RATIO=8, N_LANES=2, W=12 build: same counting stimulus gives out_valid every 8 cycles, with word k*2+l correct.
